decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 83 ++++++++
 tb/tb_decode_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue -- two-entry instruction queue between fetch and decode.
//
// Fetch pushes {instr_f, pc_plus_4_f} when valid_f is high and the queue has
// room. Decode consumes the head entry whenever it is valid and not stalled.
// Flush discards all queued entries.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high
//   valid_f      fetch offers instr_f / pc_plus_4_f this cycle
//   instr_f      fetched instruction word
//   pc_plus_4_f  word-addressed next PC accompanying instr_f
//   stall        decode cannot take the head entry this cycle
//   flush        drop every queued entry (branch, exception, interrupt, rti)
//   instr_d      head instruction, NOP_INSTR when empty
//   pc_plus_4_d  head pc_plus_4, 0 when empty
//   valid_d      head entry is valid
//   full         two entries held; fetch must hold its PC
//   count        number of valid entries (0..2)
module decode_queue #(
  parameter logic [31:0] NOP_INSTR = 32'h00000000,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_f,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_plus_4_f,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus_4_d,
  output logic        valid_d,
  output logic        full,
  output logic [1:0]  count
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
  } entry_t;

  entry_t [1:0] mem;
  logic         rp, wp;
  logic         push, pop;

  // Status comes from registered count only, so stall/flush/valid_f never
  // reach full or valid_d combinationally.
  assign full    = (count == FULL_CNT);
  assign valid_d = (count != 2'd0);

  // A full queue refuses valid_f even when a pop frees a slot this cycle.
  assign push = valid_f & ~full & ~flush;
  assign pop  = valid_d & ~stall & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp    <= 1'b0;
      wp    <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      rp    <= 1'b0;
      wp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Entry storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= '{instr: instr_f, pc_plus_4: pc_plus_4_f};
  end

  assign instr_d     = valid_d ? mem[rp].instr     : NOP_INSTR;
  assign pc_plus_4_d = valid_d ? mem[rp].pc_plus_4 : 32'h0;

endmodule

// File: tb/tb_decode_queue.sv
// Directed and randomized checks for decode_queue.
module tb_decode_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_f;
  logic [31:0] instr_f;
  logic [31:0] pc_plus_4_f;
  logic        stall;
  logic        flush;
  logic [31:0] instr_d;
  logic [31:0] pc_plus_4_d;
  logic        valid_d;
  logic        full;
  logic [1:0]  count;

  int total = 0;
  int passed = 0;

  decode_queue #(.NOP_INSTR(32'h00000000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .valid_f(valid_f), .instr_f(instr_f),
    .pc_plus_4_f(pc_plus_4_f), .stall(stall), .flush(flush),
    .instr_d(instr_d), .pc_plus_4_d(pc_plus_4_d), .valid_d(valid_d),
    .full(full), .count(count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic s, input logic f);
    valid_f = v; instr_f = i; pc_plus_4_f = p; stall = s; flush = f;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); step();
    total++; if (valid_d !== 1'b0) $display("FAIL reset_valid_d got %b exp 0", valid_d); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
    total++; if (count !== 2'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
    total++; if (instr_d !== 32'h0) $display("FAIL reset_instr_d got %h exp 00000000", instr_d); else passed++;
    total++; if (pc_plus_4_d !== 32'h0) $display("FAIL reset_pc got %h exp 00000000", pc_plus_4_d); else passed++;
    reset = 1'b0;
    step();
    total++; if (count !== 2'd0) $display("FAIL post_reset_count got %0d exp 0", count); else passed++;
  endtask

  // Streaming with no stall: each word shows up the edge after it is pushed.
  task automatic test_stream();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'hA0; exp_i[1] = 32'hA1; exp_i[2] = 32'hA2;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, exp_i[k], 32'(k + 1), 1'b0, 1'b0);
      step();
      total++; if (instr_d !== exp_i[k]) $display("FAIL stream_instr[%0d] got %h exp %h", k, instr_d, exp_i[k]); else passed++;
      total++; if (pc_plus_4_d !== 32'(k + 1)) $display("FAIL stream_pc[%0d] got %h exp %h", k, pc_plus_4_d, k + 1); else passed++;
      total++; if (count !== 2'd1) $display("FAIL stream_count[%0d] got %0d exp 1", k, count); else passed++;
      total++; if (full !== 1'b0) $display("FAIL stream_full[%0d] got %b exp 0", k, full); else passed++;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (count !== 2'd0) $display("FAIL stream_drain got %0d exp 0", count); else passed++;
  endtask

  task automatic test_stall();
    drive(1'b1, 32'hB0, 32'h10, 1'b1, 1'b0);
    step();
    total++; if (count !== 2'd1) $display("FAIL stall_count1 got %0d exp 1", count); else passed++;
    drive(1'b1, 32'hB1, 32'h11, 1'b1, 1'b0);
    step();
    total++; if (count !== 2'd2) $display("FAIL stall_count2 got %0d exp 2", count); else passed++;
    total++; if (full !== 1'b1) $display("FAIL stall_full got %b exp 1", full); else passed++;
    drive(1'b1, 32'hB2, 32'h12, 1'b1, 1'b0);
    step();
    total++; if (count !== 2'd2) $display("FAIL stall_ignore_count got %0d exp 2", count); else passed++;
    total++; if (instr_d !== 32'hB0) $display("FAIL stall_head got %h exp 000000b0", instr_d); else passed++;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (instr_d !== 32'hB1) $display("FAIL stall_second got %h exp 000000b1", instr_d); else passed++;
    total++; if (pc_plus_4_d !== 32'h11) $display("FAIL stall_second_pc got %h exp 00000011", pc_plus_4_d); else passed++;
    step();
    total++; if (valid_d !== 1'b0) $display("FAIL stall_b2_dropped valid_d got %b exp 0", valid_d); else passed++;
  endtask

  // Full queue with pop: offered word is refused that cycle, taken the next.
  task automatic test_full_pop();
    drive(1'b1, 32'hC0, 32'h20, 1'b1, 1'b0); step();
    drive(1'b1, 32'hC1, 32'h21, 1'b1, 1'b0); step();
    drive(1'b1, 32'hC2, 32'h22, 1'b0, 1'b0);
    step();
    total++; if (count !== 2'd1) $display("FAIL fullpop_count got %0d exp 1", count); else passed++;
    total++; if (instr_d !== 32'hC1) $display("FAIL fullpop_head got %h exp 000000c1", instr_d); else passed++;
    step();
    total++; if (instr_d !== 32'hC2) $display("FAIL fullpop_c2 got %h exp 000000c2", instr_d); else passed++;
    total++; if (count !== 2'd1) $display("FAIL fullpop_count2 got %0d exp 1", count); else passed++;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();
    total++; if (count !== 2'd0) $display("FAIL fullpop_drain got %0d exp 0", count); else passed++;
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hE0, 32'h30, 1'b1, 1'b0); step();
    drive(1'b1, 32'hE1, 32'h31, 1'b1, 1'b0); step();
    drive(1'b1, 32'hD0, 32'h40, 1'b0, 1'b1);
    step();
    total++; if (count !== 2'd0) $display("FAIL flush_count got %0d exp 0", count); else passed++;
    total++; if (valid_d !== 1'b0) $display("FAIL flush_valid got %b exp 0", valid_d); else passed++;
    total++; if (instr_d !== 32'h0) $display("FAIL flush_instr got %h exp 00000000", instr_d); else passed++;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    total++; if (valid_d !== 1'b0) $display("FAIL flush_d0_dropped valid_d got %b exp 0", valid_d); else passed++;
    drive(1'b1, 32'hF0, 32'h50, 1'b0, 1'b0);
    step();
    total++; if (instr_d !== 32'hF0) $display("FAIL flush_refill got %h exp 000000f0", instr_d); else passed++;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();
  endtask

  // Reset pulsed between edges must clear state before the next edge.
  task automatic test_async_reset();
    drive(1'b1, 32'h60, 32'h61, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    total++; if (count !== 2'd1) $display("FAIL areset_pre_count got %0d exp 1", count); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (valid_d !== 1'b0) $display("FAIL areset_valid got %b exp 0", valid_d); else passed++;
    total++; if (count !== 2'd0) $display("FAIL areset_count got %0d exp 0", count); else passed++;
    total++; if (instr_d !== 32'h0) $display("FAIL areset_instr got %h exp 00000000", instr_d); else passed++;
    #1 reset = 1'b0;
    drive(1'b1, 32'h70, 32'h71, 1'b0, 1'b0);
    step();
    total++; if (instr_d !== 32'h70) $display("FAIL areset_first_push got %h exp 00000070", instr_d); else passed++;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();
  endtask

  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
  } ent_t;

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    logic m_push, m_pop;
    int fails = 0;
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(9, 0) < 7, $urandom, $urandom,
            $urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0);
      m_push = valid_f && q.size() < 2 && !flush;
      m_pop  = q.size() != 0 && !stall && !flush;
      e.i = instr_f; e.p = pc_plus_4_f;
      step();
      if (flush) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(e);
      end
      total++;
      if (count !== 2'(q.size()) || full !== (q.size() == 2) || valid_d !== (q.size() != 0)) begin
        fails++;
        if (fails <= 10) $display("FAIL rand_status cyc %0d count %0d full %b valid %b exp count %0d", c, count, full, valid_d, q.size());
      end else passed++;
      if (q.size() != 0) begin
        total++;
        if (instr_d !== q[0].i || pc_plus_4_d !== q[0].p) begin
          fails++;
          if (fails <= 10) $display("FAIL rand_head cyc %0d got %h/%h exp %h/%h", c, instr_d, pc_plus_4_d, q[0].i, q[0].p);
        end else passed++;
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); step();
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_full_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
